vscale_hasti_arbiter: RTL
=========================

Name: vscale_hasti_arbiter

Overview:
- Two-master, one-slave HASTI (AHB-lite) arbiter in front of the single shared SRAM port, so two vscale core data ports can share it.
- Arbitrates address phases round-robin, honours hmastlock, and tracks the data-phase owner.
- Routes hwdata to the slave, and hrdata/hready/hresp back to the correct master.
- Purely HASTI on both sides; no buffering of losing requests (the loser is stalled via hready).

Parameters:
INIT_PRIO, 0, master that wins the first simultaneous request after reset (0 or 1)

Ports:
hclk  input  1  clock, all state on posedge
reset  input  1  asynchronous, active-high reset
m0_haddr, m1_haddr  input  `HASTI_ADDR_WIDTH  master address
m0_hwrite, m1_hwrite  input  1  write flag
m0_hsize, m1_hsize  input  `HASTI_SIZE_WIDTH  transfer size
m0_hburst, m1_hburst  input  `HASTI_BURST_WIDTH  burst (passed through)
m0_hmastlock, m1_hmastlock  input  1  locked-sequence request
m0_hprot, m1_hprot  input  `HASTI_PROT_WIDTH  protection (passed through)
m0_htrans, m1_htrans  input  `HASTI_TRANS_WIDTH  transfer type
m0_hwdata, m1_hwdata  input  `HASTI_BUS_WIDTH  write data (data phase)
m0_hrdata, m1_hrdata  output  `HASTI_BUS_WIDTH  read data
m0_hready, m1_hready  output  1  per-master ready
m0_hresp, m1_hresp  output  `HASTI_RESP_WIDTH  per-master response
s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata  output  as master  to slave
s_hrdata  input  `HASTI_BUS_WIDTH  slave read data
s_hready  input  1  slave ready
s_hresp  input  `HASTI_RESP_WIDTH  slave response

Behaviour:
- State registers:
  - dp_valid: data phase in flight.
  - dp_owner: 0/1.
  - prio: next-preferred master.
  - locked: lock held.
  - lock_owner: 0/1.
- Reset (async, active-high): dp_valid=0, dp_owner=0, prio=INIT_PRIO, locked=0, lock_owner=0. While reset is high:
  - s_htrans=IDLE; other s_* address signals = master 0 values.
  - m*_hready=1, m*_hresp=OKAY, m*_hrdata=s_hrdata.
- req_m = (mM_htrans == NONSEQ).
  - SEQ is treated as NONSEQ, because vscale issues single transfers only.
  - IDLE and BUSY are no request.
- Grant (combinational), evaluated only when s_hready=1:
  - locked=1: only lock_owner is eligible.
  - Else, single requester wins.
  - Else, both requesting: prio wins.
  - s_hready=0: no grant, s_htrans=IDLE.
- Slave address mux: s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot driven from the granted master; s_htrans=NONSEQ if granted else IDLE.
- s_hwdata = dp_owner's hwdata (data is one cycle after address).
- On posedge with s_hready=1:
  - dp_valid <= grant_valid; dp_owner <= granted master.
  - prio <= other master when a grant occurs; unchanged otherwise.
  - locked <= granted master's hmastlock; lock_owner <= granted master.
  - locked clears only when lock_owner issues a NONSEQ with hmastlock=0 or goes IDLE.
- s_hready=0: all state holds.
- Master return path:
  - mM_hrdata = s_hrdata.
  - mM_hresp = s_hresp if (dp_valid && dp_owner==M), else OKAY.
  - mM_hready = dp_ok_M && !(req_M && !granted_M).
  - dp_ok_M = s_hready if (dp_valid && dp_owner==M), else 1.
- A denied master sees hready=0 and must hold its address; this is standard AHB, and no internal queue exists.
- Latency: an uncontended transfer adds zero cycles (combinational address path). A contended loser waits exactly one accepted transfer when unlocked.
- Back-to-back same master: allowed only when the other master is not requesting, or after alternation. Strict alternation under continuous contention.
- A reset asserted mid-data-phase drops the in-flight transfer. No partial write is issued after reset deassertion.

Test Plan:
- m0 NONSEQ read addr 0x10, m1 IDLE -> s_htrans=NONSEQ, s_haddr=0x10 same cycle; m0_hready=1; next cycle m0_hrdata=s_hrdata.
- Both NONSEQ at cycle 0 after reset (INIT_PRIO=0) -> m0 granted, m1_hready=0; cycle 1 m1 granted with its held address; prio alternates on continued contention (0,1,0,1).
- m0 write 0x20 data 0xDEADBEEF while m1 reads 0x24 same cycle -> s_hwdata=0xDEADBEEF in the cycle after m0's grant; m1's address issued that cycle; m1_hrdata valid the following cycle.
- m1 asserts hmastlock for 3 transfers while m0 requests continuously -> m0_hready=0 for all 3; m0 granted on the cycle m1 drops hmastlock/goes IDLE.
- s_hready forced 0 for 2 cycles during m0 data phase -> m0_hready=0 both cycles, no new grant, state frozen; resumes on s_hready=1.
- Assert reset during an m1 write data phase -> s_htrans=IDLE immediately, both hready=1; after release, dp_valid=0 and the first grant follows INIT_PRIO.

Source files
------------

// File: rtl/vscale_hasti_arbiter_if.sv
// HASTI (AHB-lite) bus bundle: one address/data channel between a bus master
// and a bus slave. The arbiter is the slave on each core port and the master on the SRAM port.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

interface vscale_hasti_arbiter_if;
  logic [`HASTI_ADDR_WIDTH-1:0]  haddr;
  logic                          hwrite;
  logic [`HASTI_SIZE_WIDTH-1:0]  hsize;
  logic [`HASTI_BURST_WIDTH-1:0] hburst;
  logic                          hmastlock;
  logic [`HASTI_PROT_WIDTH-1:0]  hprot;
  logic [`HASTI_TRANS_WIDTH-1:0] htrans;
  logic [`HASTI_BUS_WIDTH-1:0]   hwdata;
  logic [`HASTI_BUS_WIDTH-1:0]   hrdata;
  logic                          hready;
  logic [`HASTI_RESP_WIDTH-1:0]  hresp;

  modport master (
    output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/vscale_hasti_arbiter.sv
// Two-master / one-slave HASTI arbiter: round-robin address-phase grant with
// hmastlock support; losers are stalled through hready, nothing is buffered.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

module vscale_hasti_arbiter #(
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic                   hclk,
  input  logic                   reset,
  vscale_hasti_arbiter_if.slave  m0,
  vscale_hasti_arbiter_if.slave  m1,
  vscale_hasti_arbiter_if.master s
);

  localparam logic [`HASTI_TRANS_WIDTH-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [`HASTI_TRANS_WIDTH-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [`HASTI_TRANS_WIDTH-1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [`HASTI_RESP_WIDTH-1:0]  HRESP_OKAY    = '0;

  logic dp_valid_reg;
  logic dp_owner_reg;
  logic prio_reg;
  logic locked_reg;
  logic lock_owner_reg;

  logic [1:0] req;
  logic [1:0] lock_req;
  logic       lock_hold;
  logic       grant_valid;
  logic       grant_id;

  // vscale only issues single transfers, so SEQ is just another new request.
  assign req[0] = (m0.htrans == HTRANS_NONSEQ) || (m0.htrans == HTRANS_SEQ);
  assign req[1] = (m1.htrans == HTRANS_NONSEQ) || (m1.htrans == HTRANS_SEQ);
  assign lock_req = {m1.hmastlock, m0.hmastlock};

  // A lock only excludes the other master while its owner keeps issuing locked
  // requests; the cycle the owner goes idle or unlocks, normal arbitration resumes.
  assign lock_hold = locked_reg && req[lock_owner_reg] && lock_req[lock_owner_reg];

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (!reset && s.hready) begin
      if (lock_hold) begin
        grant_valid = 1'b1;
        grant_id    = lock_owner_reg;
      end else if (&req) begin
        grant_valid = 1'b1;
        grant_id    = prio_reg;
      end else if (req[0]) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req[1]) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign s.haddr     = grant_id ? m1.haddr     : m0.haddr;
  assign s.hwrite    = grant_id ? m1.hwrite    : m0.hwrite;
  assign s.hsize     = grant_id ? m1.hsize     : m0.hsize;
  assign s.hburst    = grant_id ? m1.hburst    : m0.hburst;
  assign s.hmastlock = grant_id ? m1.hmastlock : m0.hmastlock;
  assign s.hprot     = grant_id ? m1.hprot     : m0.hprot;
  assign s.htrans    = grant_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s.hwdata    = dp_owner_reg ? m1.hwdata : m0.hwdata;

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      dp_valid_reg   <= 1'b0;
      dp_owner_reg   <= 1'b0;
      prio_reg       <= INIT_PRIO;
      locked_reg     <= 1'b0;
      lock_owner_reg <= 1'b0;
    end else if (s.hready) begin
      dp_valid_reg <= grant_valid;
      dp_owner_reg <= grant_id;
      locked_reg   <= grant_valid && lock_req[grant_id];
      if (grant_valid) begin
        prio_reg       <= ~grant_id;
        lock_owner_reg <= grant_id;
      end
    end
  end

  logic [1:0]                    hready_vec;
  logic [`HASTI_RESP_WIDTH-1:0]  hresp_vec [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      logic own_dp;
      logic granted;
      logic dp_ok;
      assign own_dp  = dp_valid_reg && (dp_owner_reg == 1'(gi));
      assign granted = grant_valid && (grant_id == 1'(gi));
      assign dp_ok   = own_dp ? s.hready : 1'b1;
      assign hready_vec[gi] = reset || (dp_ok && !(req[gi] && !granted));
      assign hresp_vec[gi]  = (own_dp && !reset) ? s.hresp : HRESP_OKAY;
    end
  endgenerate

  assign m0.hrdata = s.hrdata;
  assign m1.hrdata = s.hrdata;
  assign m0.hready = hready_vec[0];
  assign m1.hready = hready_vec[1];
  assign m0.hresp  = hresp_vec[0];
  assign m1.hresp  = hresp_vec[1];

endmodule
